// File: rtl/recovery_core_responder_pkg.sv
// Shared types for the core-side rapid-recovery responder: FSM state encoding
// and the controller register-file write-port bundle.
package recovery_core_responder_pkg;

  // Controller-side RF addresses are one bit wider than the core RF; port b is offset by 16.
  localparam int unsigned RrfAddrWidth = 6;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    HALT_PEND = 3'd1,
    DRAIN     = 3'd2,
    HALTED    = 3'd3,
    RESUME    = 3'd4
  } responder_state_e;

  typedef struct packed {
    logic                    we_a;
    logic [RrfAddrWidth-1:0] waddr_a;
    logic                    we_b;
    logic [RrfAddrWidth-1:0] waddr_b;
  } regfile_write_t;

endpackage

// File: rtl/recovery_core_responder_if.sv
// Controller <-> responder link: halt/resume handshake, fetch lock and RF replay stream.
interface recovery_core_responder_if #(
    parameter int unsigned DataWidth = 32
);
    import recovery_core_responder_pkg::*;

    // Handshake: debug_req and debug_resume are single-cycle pulses with no ready; debug_rsp is
    // a level that stays high while the core is halted and drained, and drops after debug_resume.
    logic                 setback;
    logic                 debug_req;
    logic                 debug_rsp;
    logic                 debug_resume;
    logic                 instr_lock;
    logic                 recover;
    regfile_write_t       rrf_wport;
    logic [DataWidth-1:0] rrf_rdata_a;
    logic [DataWidth-1:0] rrf_rdata_b;

    modport master (
        output setback, debug_req, debug_resume, instr_lock, recover,
        output rrf_wport, rrf_rdata_a, rrf_rdata_b,
        input  debug_rsp
    );

    modport slave (
        input  setback, debug_req, debug_resume, instr_lock, recover,
        input  rrf_wport, rrf_rdata_a, rrf_rdata_b,
        output debug_rsp
    );

endinterface

// File: rtl/recovery_core_responder_outstanding_counter.sv
// Tracks in-flight instruction fetches; saturates and flags an error on over/underflow.
module recovery_outstanding_counter #(
    parameter int unsigned MaxOutstand = 2,
    localparam int unsigned CntWidth   = $clog2(MaxOutstand + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                err_o
);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                at_max, at_zero, inc_only, dec_only;

    assign at_max   = (cnt_q == CntWidth'(MaxOutstand));
    assign at_zero  = (cnt_q == '0);
    assign inc_only = inc_i & ~dec_i;
    assign dec_only = dec_i & ~inc_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_only && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_only && !at_zero) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign err_o = ~clear_i & ((inc_only & at_max) | (dec_only & at_zero));
    assign cnt_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/recovery_core_responder.sv
// Core-side end of the DMR rapid-recovery handshake: halts and drains the core pair,
// gates fetches, and replays backup register-file writes into the core RF ports.
module recovery_core_responder
    import recovery_core_responder_pkg::*;
#(
    parameter int unsigned RFAddrWidth  = 5,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned MaxOutstand  = 2,
    parameter int unsigned HaltTimeout  = 255,
    localparam int unsigned CntWidth    = $clog2(MaxOutstand + 1),
    localparam int unsigned TimerWidth  = $clog2(HaltTimeout + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    recovery_core_responder_if.slave ctrl,
    output logic                   core_debug_req_o,
    input  logic                   core_halted_i,
    output logic                   core_resume_o,
    output logic                   core_recover_o,
    input  logic                   core_ireq_i,
    output logic                   core_ignt_o,
    output logic                   ireq_o,
    input  logic                   ignt_i,
    input  logic                   irvalid_i,
    output logic                   core_rf_we_a_o,
    output logic [RFAddrWidth-1:0] core_rf_waddr_a_o,
    output logic [DataWidth-1:0]   core_rf_wdata_a_o,
    output logic                   core_rf_we_b_o,
    output logic [RFAddrWidth-1:0] core_rf_waddr_b_o,
    output logic [DataWidth-1:0]   core_rf_wdata_b_o,
    output logic                   fatal_o,
    output responder_state_e       state_o,
    output logic [CntWidth-1:0]    outstanding_o
);

    localparam logic [2:0] StRun      = 3'd0;
    localparam logic [2:0] StHaltPend = 3'd1;
    localparam logic [2:0] StDrain    = 3'd2;
    localparam logic [2:0] StHalted   = 3'd3;
    localparam logic [2:0] StResume   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic                  fatal_q, fatal_d;
    logic                  recover_q;
    logic                  we_a_q, we_b_q;
    logic [RFAddrWidth-1:0] waddr_a_q, waddr_b_q;
    logic [DataWidth-1:0]   wdata_a_q, wdata_b_q;

    logic [CntWidth-1:0]   cnt;
    logic                  cnt_err, timeout, halting, fwd_a, fwd_b;

    assign ireq_o      = core_ireq_i & ~ctrl.instr_lock & (cnt < CntWidth'(MaxOutstand));
    assign core_ignt_o = ireq_o & ignt_i;

    recovery_outstanding_counter #(
        .MaxOutstand(MaxOutstand)
    ) u_outstanding (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(ctrl.setback),
        .inc_i  (core_ignt_o),
        .dec_i  (irvalid_i),
        .cnt_o  (cnt),
        .err_o  (cnt_err)
    );

    assign halting = (state_q == StHaltPend) | (state_q == StDrain);
    assign timeout = halting & (timer_q == TimerWidth'(HaltTimeout));

    // A timed-out halt freezes the FSM; only setback or reset moves it on.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:      if (ctrl.debug_req) state_d = StHaltPend;
            StHaltPend: if (core_halted_i && !timeout) state_d = StDrain;
            StDrain:    if (cnt == '0 && !timeout) state_d = StHalted;
            StHalted:   if (ctrl.debug_resume) state_d = StResume;
            StResume:   state_d = StRun;
            default:    state_d = StRun;
        endcase
        if (ctrl.setback) state_d = ctrl.debug_req ? StHaltPend : StRun;
    end

    always_comb begin
        timer_d = '0;
        if (!ctrl.setback && halting) timer_d = timeout ? timer_q : timer_q + 1'b1;
    end

    assign fatal_d = fatal_q | timeout | cnt_err;
    assign fwd_a   = ctrl.recover & ctrl.rrf_wport.we_a;
    assign fwd_b   = ctrl.recover & ctrl.rrf_wport.we_b;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StRun;
            timer_q <= '0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fatal_q <= fatal_d;
        end
    end

    // Address/data only update on a forwarded write so the core sees stable values otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            recover_q <= 1'b0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            waddr_a_q <= '0;
            waddr_b_q <= '0;
            wdata_a_q <= '0;
            wdata_b_q <= '0;
        end else if (ctrl.setback) begin
            recover_q <= 1'b0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            waddr_a_q <= '0;
            waddr_b_q <= '0;
            wdata_a_q <= '0;
            wdata_b_q <= '0;
        end else begin
            recover_q <= ctrl.recover;
            we_a_q    <= fwd_a;
            we_b_q    <= fwd_b;
            if (fwd_a) begin
                waddr_a_q <= RFAddrWidth'(ctrl.rrf_wport.waddr_a);
                wdata_a_q <= ctrl.rrf_rdata_a;
            end
            if (fwd_b) begin
                waddr_b_q <= RFAddrWidth'(ctrl.rrf_wport.waddr_b);
                wdata_b_q <= ctrl.rrf_rdata_b;
            end
        end
    end

    assign core_debug_req_o  = ((state_q == StRun) & ctrl.debug_req) | (state_q == StHaltPend);
    assign core_resume_o     = (state_q == StResume);
    assign ctrl.debug_rsp    = (state_q == StHalted);
    assign core_recover_o    = recover_q;
    assign core_rf_we_a_o    = we_a_q;
    assign core_rf_waddr_a_o = waddr_a_q;
    assign core_rf_wdata_a_o = wdata_a_q;
    assign core_rf_we_b_o    = we_b_q;
    assign core_rf_waddr_b_o = waddr_b_q;
    assign core_rf_wdata_b_o = wdata_b_q;
    assign fatal_o           = fatal_q;
    assign state_o           = responder_state_e'(state_q);
    assign outstanding_o     = cnt;

endmodule

// File: tb/tb_recovery_core_responder.sv
// Directed bench for recovery_core_responder: halt/drain/resume, fetch gating,
// RF replay, halt timeout, counter underflow and setback.
module tb_recovery_core_responder;
  import recovery_core_responder_pkg::*;

  localparam int unsigned RFAddrWidth = 5;
  localparam int unsigned DataWidth   = 32;
  localparam int unsigned MaxOutstand = 2;
  localparam int unsigned HaltTimeout = 255;
  localparam int unsigned BeatW       = 2 * (1 + RFAddrWidth + DataWidth);

  logic                   clk_i;
  logic                   rst_ni;
  logic                   core_debug_req_o;
  logic                   core_halted_i;
  logic                   core_resume_o;
  logic                   core_recover_o;
  logic                   core_ireq_i;
  logic                   core_ignt_o;
  logic                   ireq_o;
  logic                   ignt_i;
  logic                   irvalid_i;
  logic                   core_rf_we_a_o;
  logic [RFAddrWidth-1:0] core_rf_waddr_a_o;
  logic [DataWidth-1:0]   core_rf_wdata_a_o;
  logic                   core_rf_we_b_o;
  logic [RFAddrWidth-1:0] core_rf_waddr_b_o;
  logic [DataWidth-1:0]   core_rf_wdata_b_o;
  logic                   fatal_o;
  responder_state_e       state_o;
  logic [1:0]             outstanding_o;

  int n_checks;
  int n_errors;
  logic [BeatW-1:0] exp_q[$];

  recovery_core_responder_if #(.DataWidth(DataWidth)) ctrl_if ();

  recovery_core_responder #(
    .RFAddrWidth(RFAddrWidth),
    .DataWidth  (DataWidth),
    .MaxOutstand(MaxOutstand),
    .HaltTimeout(HaltTimeout)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .ctrl             (ctrl_if.slave),
    .core_debug_req_o (core_debug_req_o),
    .core_halted_i    (core_halted_i),
    .core_resume_o    (core_resume_o),
    .core_recover_o   (core_recover_o),
    .core_ireq_i      (core_ireq_i),
    .core_ignt_o      (core_ignt_o),
    .ireq_o           (ireq_o),
    .ignt_i           (ignt_i),
    .irvalid_i        (irvalid_i),
    .core_rf_we_a_o   (core_rf_we_a_o),
    .core_rf_waddr_a_o(core_rf_waddr_a_o),
    .core_rf_wdata_a_o(core_rf_wdata_a_o),
    .core_rf_we_b_o   (core_rf_we_b_o),
    .core_rf_waddr_b_o(core_rf_waddr_b_o),
    .core_rf_wdata_b_o(core_rf_wdata_b_o),
    .fatal_o          (fatal_o),
    .state_o          (state_o),
    .outstanding_o    (outstanding_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drive_idle();
    ctrl_if.setback      = 1'b0;
    ctrl_if.debug_req    = 1'b0;
    ctrl_if.debug_resume = 1'b0;
    ctrl_if.instr_lock   = 1'b0;
    ctrl_if.recover      = 1'b0;
    ctrl_if.rrf_wport    = '0;
    ctrl_if.rrf_rdata_a  = '0;
    ctrl_if.rrf_rdata_b  = '0;
    core_halted_i        = 1'b0;
    core_ireq_i          = 1'b0;
    ignt_i               = 1'b0;
    irvalid_i            = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_ni = 1'b0;
    step(2);
    rst_ni = 1'b1;
    step(1);
  endtask

  task automatic pulse_debug_req();
    ctrl_if.debug_req = 1'b1;
    step(1);
    ctrl_if.debug_req = 1'b0;
  endtask

  task automatic pulse_resume();
    ctrl_if.debug_resume = 1'b1;
    step(1);
    ctrl_if.debug_resume = 1'b0;
  endtask

  function automatic logic [BeatW-1:0] rf_obs();
    return {core_rf_we_a_o, core_rf_waddr_a_o, core_rf_wdata_a_o,
            core_rf_we_b_o, core_rf_waddr_b_o, core_rf_wdata_b_o};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive_idle();
    rst_ni = 1'b0;
    #12;
    check("rst_state", state_o, RUN);
    check("rst_outs", {core_debug_req_o, core_resume_o, core_recover_o, core_ignt_o, ireq_o,
                       ctrl_if.debug_rsp, fatal_o}, 7'b0);
    check("rst_rf", rf_obs(), '0);
    check("rst_cnt", outstanding_o, 2'd0);
    rst_ni = 1'b1;
    step(1);

    // idle halt: core_halted 3 cycles after request, rsp 2 cycles after core_halted
    ctrl_if.debug_req = 1'b1;
    #1;
    check("halt_req_comb", core_debug_req_o, 1'b1);
    step(1);
    ctrl_if.debug_req = 1'b0;
    check("halt_pend_state", state_o, HALT_PEND);
    check("halt_pend_req", core_debug_req_o, 1'b1);
    step(2);
    core_halted_i = 1'b1;
    step(1);
    check("drain_state", state_o, DRAIN);
    check("drain_rsp", ctrl_if.debug_rsp, 1'b0);
    check("drain_req", core_debug_req_o, 1'b0);
    step(1);
    check("halted_rsp", ctrl_if.debug_rsp, 1'b1);
    pulse_debug_req();
    check("req_ignored_halted", state_o, HALTED);
    pulse_resume();
    check("resume_pulse", core_resume_o, 1'b1);
    check("resume_rsp_drop", ctrl_if.debug_rsp, 1'b0);
    core_halted_i = 1'b0;
    step(1);
    check("resume_one_cycle", core_resume_o, 1'b0);
    check("back_to_run", state_o, RUN);
    pulse_resume();
    check("resume_ignored_run", {state_o, core_resume_o}, {RUN, 1'b0});

    // two fetches in flight, then halt: rsp waits for the second response
    core_ireq_i = 1'b1;
    ignt_i      = 1'b1;
    #1;
    check("fetch_pass_comb", {ireq_o, core_ignt_o}, 2'b11);
    step(2);
    check("cnt_two", outstanding_o, 2'd2);
    check("fetch_block_full", {ireq_o, core_ignt_o}, 2'b00);
    core_ireq_i = 1'b0;
    ignt_i      = 1'b0;
    pulse_debug_req();
    core_halted_i = 1'b1;
    step(2);
    check("drain_wait", {state_o, ctrl_if.debug_rsp}, {DRAIN, 1'b0});
    irvalid_i = 1'b1;
    step(1);
    irvalid_i = 1'b0;
    check("cnt_one", outstanding_o, 2'd1);
    step(1);
    check("drain_wait2", ctrl_if.debug_rsp, 1'b0);
    irvalid_i = 1'b1;
    step(1);
    irvalid_i = 1'b0;
    check("rsp_before_last", ctrl_if.debug_rsp, 1'b0);
    step(1);
    check("rsp_after_last", ctrl_if.debug_rsp, 1'b1);
    check("cnt_zero", outstanding_o, 2'd0);
    pulse_resume();
    core_halted_i = 1'b0;
    step(1);

    // instruction lock blocks fetches
    ctrl_if.instr_lock = 1'b1;
    core_ireq_i        = 1'b1;
    ignt_i             = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("lock_gate", {ireq_o, core_ignt_o}, 2'b00);
      step(1);
    end
    check("lock_cnt", outstanding_o, 2'd0);
    ctrl_if.instr_lock = 1'b0;
    core_ireq_i        = 1'b0;
    ignt_i             = 1'b0;

    // RF replay: 16 beats, 1-cycle latency
    ctrl_if.recover = 1'b1;
    for (int n = 0; n < 16; n++) begin
      ctrl_if.rrf_wport.we_a    = 1'b1;
      ctrl_if.rrf_wport.waddr_a = 6'(n);
      ctrl_if.rrf_wport.we_b    = 1'b1;
      ctrl_if.rrf_wport.waddr_b = 6'(16 + n);
      ctrl_if.rrf_rdata_a       = 32'hA0 + 32'(n);
      ctrl_if.rrf_rdata_b       = 32'hB0 + 32'(n);
      exp_q.push_back({1'b1, 5'(n), 32'hA0 + 32'(n), 1'b1, 5'(16 + n), 32'hB0 + 32'(n)});
      step(1);
      check("rf_beat", rf_obs(), exp_q.pop_front());
      if (n == 0) check("rf_recover", core_recover_o, 1'b1);
    end
    ctrl_if.rrf_wport   = '0;
    ctrl_if.rrf_rdata_a = 32'hDEAD;
    ctrl_if.rrf_rdata_b = 32'hBEEF;
    step(1);
    check("rf_hold", rf_obs(), {1'b0, 5'd15, 32'hAF, 1'b0, 5'd31, 32'hBF});
    ctrl_if.recover           = 1'b0;
    ctrl_if.rrf_wport.we_a    = 1'b1;
    ctrl_if.rrf_wport.waddr_a = 6'd3;
    step(1);
    check("rf_no_recover", {core_recover_o, core_rf_we_a_o, core_rf_waddr_a_o}, {1'b0, 1'b0, 5'd15});
    ctrl_if.rrf_wport = '0;

    // setback mid-drain with one fetch in flight
    core_ireq_i = 1'b1;
    ignt_i      = 1'b1;
    step(1);
    core_ireq_i = 1'b0;
    ignt_i      = 1'b0;
    pulse_debug_req();
    core_halted_i = 1'b1;
    step(2);
    check("sb_pre", {state_o, outstanding_o}, {DRAIN, 2'd1});
    ctrl_if.setback = 1'b1;
    step(1);
    ctrl_if.setback = 1'b0;
    check("sb_state", state_o, RUN);
    check("sb_cnt", outstanding_o, 2'd0);
    check("sb_rf", rf_obs(), '0);
    ctrl_if.setback   = 1'b1;
    ctrl_if.debug_req = 1'b1;
    step(1);
    ctrl_if.setback   = 1'b0;
    ctrl_if.debug_req = 1'b0;
    check("sb_with_req", state_o, HALT_PEND);
    step(2);
    check("sb_req_halted", ctrl_if.debug_rsp, 1'b1);
    pulse_resume();
    core_halted_i = 1'b0;
    step(1);

    // counter underflow sets sticky fatal
    irvalid_i = 1'b1;
    step(1);
    irvalid_i = 1'b0;
    check("underflow_fatal", fatal_o, 1'b1);
    check("underflow_sat", outstanding_o, 2'd0);
    apply_reset();
    check("fatal_cleared", fatal_o, 1'b0);

    // halt timeout: core never halts
    pulse_debug_req();
    step(250);
    check("timeout_early", fatal_o, 1'b0);
    step(10);
    check("timeout_fatal", fatal_o, 1'b1);
    check("timeout_rsp", ctrl_if.debug_rsp, 1'b0);
    core_halted_i = 1'b1;
    step(2);
    check("timeout_hold", state_o, HALT_PEND);
    core_halted_i   = 1'b0;
    ctrl_if.setback = 1'b1;
    step(1);
    ctrl_if.setback = 1'b0;
    check("timeout_sb", {state_o, fatal_o}, {RUN, 1'b1});
    step(5);
    check("fatal_sticky", fatal_o, 1'b1);
    apply_reset();
    check("fatal_reset", fatal_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
